// File: rtl/trig_ctrl_pkg.sv
// Shared types and constants for the trigger arm controller.
// The FSM states are one-hot so that each state decode is a single flop bit.
package trig_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ARMED   = 4'b0010,
        FIRE    = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    localparam int GAP_CYCLES_DEFAULT = 8;
    localparam int LAST_SRC_W         = 3;

endpackage

// File: rtl/trigger_arm_ctrl_rr_arbiter.sv
// Combinational round-robin picker: grants the first request at or after the
// pointer, wrapping to the lowest request when nothing sits above the pointer.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [NUM_SRC-1:0] w_upper;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_pool;
    logic [NUM_SRC-1:0] w_sel [IDX_W];

    // w_upper has every bit at or above the pointer set
    assign w_upper  = ~((NUM_SRC'(1) << i_ptr) - NUM_SRC'(1));
    assign w_masked = i_req & w_upper;
    assign w_pool   = (|w_masked) ? w_masked : i_req;
    assign o_grant  = w_pool & (~w_pool + NUM_SRC'(1));
    assign o_valid  = |i_req;

    generate
        for (genvar gb = 0; gb < IDX_W; gb++) begin : g_idx_bit
            for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
                if (((gi >> gb) & 1) != 0) begin : g_on
                    assign w_sel[gb][gi] = o_grant[gi];
                end else begin : g_off
                    assign w_sel[gb][gi] = 1'b0;
                end
            end
            assign o_idx[gb] = |w_sel[gb];
        end
    endgenerate

endmodule

// File: rtl/trigger_arm_ctrl.sv
// Arms the trigger synchroniser: round-robin grants a source, holds sync_enable
// until the trigger edge, enforces the re-arm gap, trigger count and timeout.
module trigger_arm_ctrl
    import trig_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int TIMEOUT_W  = 16,
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic [NUM_SRC-1:0]    i_cfg_src_mask,
    input  logic [11:0]           i_cfg_delay,
    input  logic [TIMEOUT_W-1:0]  i_cfg_timeout,
    input  logic [CNT_W-1:0]      i_cfg_num_trig,
    input  logic [NUM_SRC-1:0]    i_src_req,
    input  logic                  i_trig_done_in,
    output logic [NUM_SRC-1:0]    o_src_grant,
    output logic                  o_sync_enable,
    output logic [11:0]           o_delay_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout_err,
    output logic [CNT_W-1:0]      o_trig_count,
    output logic [LAST_SRC_W-1:0] o_last_src
);

    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    state_t                r_state, w_state_next;
    logic [NUM_SRC-1:0]    r_mask;
    logic [11:0]           r_delay;
    logic [TIMEOUT_W-1:0]  r_timeout, r_tcnt, w_tcnt_next, w_tcnt_inc;
    logic [CNT_W-1:0]      r_num_trig, r_trig_count, w_trig_count_next;
    logic [LAST_SRC_W-1:0] r_ptr, w_ptr_next, r_last_src, w_last_src_next;
    logic [GAP_W-1:0]      r_gap, w_gap_next;
    logic                  r_timeout_err, w_timeout_err_next;
    logic                  r_sync_enable, w_sync_next;
    logic                  r_done, w_done_next;
    logic                  r_trig_prev;
    logic                  w_cfg_load, w_trig_rise;
    logic [NUM_SRC-1:0]    w_arb_grant, w_grant;
    logic [LAST_SRC_W-1:0] w_arb_idx;
    logic                  w_arb_valid;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (LAST_SRC_W)
    ) u_arb (
        .i_req   (i_src_req & r_mask),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_trig_rise = i_trig_done_in & ~r_trig_prev;
    assign w_tcnt_inc  = r_tcnt + TIMEOUT_W'(1);

    always_comb begin
        w_state_next       = r_state;
        w_sync_next        = 1'b0;
        w_done_next        = 1'b0;
        w_trig_count_next  = r_trig_count;
        w_timeout_err_next = r_timeout_err;
        w_ptr_next         = r_ptr;
        w_last_src_next    = r_last_src;
        w_tcnt_next        = r_tcnt;
        w_gap_next         = r_gap;
        w_grant            = '0;
        w_cfg_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_arm) begin
                    w_cfg_load         = 1'b1;
                    w_trig_count_next  = '0;
                    w_timeout_err_next = 1'b0;
                    w_state_next       = ARMED;
                end
            end
            ARMED: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else if (w_arb_valid) begin
                    w_grant         = w_arb_grant;
                    w_last_src_next = w_arb_idx;
                    w_ptr_next      = (w_arb_idx == LAST_SRC_W'(NUM_SRC - 1)) ?
                                      '0 : w_arb_idx + LAST_SRC_W'(1);
                    w_tcnt_next     = '0;
                    w_sync_next     = 1'b1;
                    w_state_next    = FIRE;
                end
            end
            FIRE: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else if (w_trig_rise) begin
                    w_trig_count_next = (&r_trig_count) ? r_trig_count
                                                        : r_trig_count + CNT_W'(1);
                    w_gap_next        = '0;
                    w_state_next      = RELEASE;
                end else if ((r_timeout != '0) && (w_tcnt_inc == r_timeout)) begin
                    w_timeout_err_next = 1'b1;
                    w_state_next       = IDLE;
                end else begin
                    w_tcnt_next = w_tcnt_inc;
                    w_sync_next = 1'b1;
                end
            end
            RELEASE: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                    if ((r_num_trig != '0) && (r_trig_count == r_num_trig)) begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = ARMED;
                    end
                end else begin
                    w_gap_next = r_gap + GAP_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sync_enable <= 1'b0;
            r_done        <= 1'b0;
            r_trig_count  <= '0;
            r_timeout_err <= 1'b0;
            r_ptr         <= '0;
            r_last_src    <= '0;
            r_tcnt        <= '0;
            r_gap         <= '0;
            r_trig_prev   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sync_enable <= w_sync_next;
            r_done        <= w_done_next;
            r_trig_count  <= w_trig_count_next;
            r_timeout_err <= w_timeout_err_next;
            r_ptr         <= w_ptr_next;
            r_last_src    <= w_last_src_next;
            r_tcnt        <= w_tcnt_next;
            r_gap         <= w_gap_next;
            r_trig_prev   <= i_trig_done_in;
        end
    end

    // Configuration is frozen for the whole sequence once armed
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_delay    <= '0;
            r_timeout  <= '0;
            r_num_trig <= '0;
        end else if (w_cfg_load) begin
            r_mask     <= i_cfg_src_mask;
            r_delay    <= i_cfg_delay;
            r_timeout  <= i_cfg_timeout;
            r_num_trig <= i_cfg_num_trig;
        end
    end

    assign o_src_grant   = w_grant;
    assign o_sync_enable = r_sync_enable;
    assign o_delay_count = r_delay;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_timeout_err = r_timeout_err;
    assign o_trig_count  = r_trig_count;
    assign o_last_src    = r_last_src;

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Randomised self-checking bench for trigger_arm_ctrl against a behavioural
// model of grant order, trigger counting and sequence timing.
module tb_trigger_arm_ctrl;

    localparam int GAP = 8;

    logic        ref_clk = 1'b0;
    logic        rst_n;
    logic        arm, abort;
    logic [3:0]  cfg_src_mask;
    logic [11:0] cfg_delay;
    logic [15:0] cfg_timeout, cfg_num_trig;
    logic [3:0]  src_req;
    logic        trig_done_in;
    logic [3:0]  src_grant;
    logic        sync_enable;
    logic [11:0] delay_count;
    logic        busy, done, timeout_err;
    logic [15:0] trig_count;
    logic [2:0]  last_src;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int mdl_ptr = 0;
    logic [3:0]  mdl_mask = 4'b0;
    logic [11:0] mdl_delay = 12'b0;

    trigger_arm_ctrl #(
        .NUM_SRC(4), .TIMEOUT_W(16), .CNT_W(16), .GAP_CYCLES(GAP)
    ) dut (
        .ref_clk        (ref_clk),
        .rst_n          (rst_n),
        .i_arm          (arm),
        .i_abort        (abort),
        .i_cfg_src_mask (cfg_src_mask),
        .i_cfg_delay    (cfg_delay),
        .i_cfg_timeout  (cfg_timeout),
        .i_cfg_num_trig (cfg_num_trig),
        .i_src_req      (src_req),
        .i_trig_done_in (trig_done_in),
        .o_src_grant    (src_grant),
        .o_sync_enable  (sync_enable),
        .o_delay_count  (delay_count),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout_err  (timeout_err),
        .o_trig_count   (trig_count),
        .o_last_src     (last_src)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge ref_clk);
    endtask

    // First qualified request at or after the pointer, wrapping; -1 if none
    function automatic int mdl_pick(input logic [3:0] reqq, input int ptr);
        for (int off = 0; off < 4; off++) begin
            int idx;
            idx = (ptr + off) % 4;
            if (((reqq >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic wait_grant(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (src_grant !== 4'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic arm_seq(input logic [3:0] m, input logic [11:0] d,
                           input logic [15:0] t, input logic [15:0] nt);
        cfg_src_mask = m; cfg_delay = d; cfg_timeout = t; cfg_num_trig = nt;
        mdl_mask = m; mdl_delay = d; fall_cyc = -1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        // Live configuration must no longer matter once armed
        cfg_src_mask = 4'($urandom);
        cfg_delay    = 12'($urandom);
        cfg_timeout  = 16'($urandom_range(1, 3));
        cfg_num_trig = 16'($urandom_range(1, 2));
        checks++;
        if (busy !== 1'b1 || trig_count !== 16'd0 || timeout_err !== 1'b0 || delay_count !== d) begin
            errors++;
            $display("FAIL arm_state busy=%b cnt=%0d err=%b delay=%h expected busy=1 cnt=0 err=0 delay=%h",
                     busy, trig_count, timeout_err, delay_count, d);
        end
    endtask

    // One ARMED->FIRE->RELEASE visit; trigger rises on the trig_after-th FIRE cycle
    task automatic do_visit(input int trig_after, input logic [3:0] next_req,
                            input bit exp_done, input int exp_cnt);
        logic [3:0] exp_grant;
        int exp_idx, done_cnt, done_at;
        bit seen, held, low_ok;
        exp_idx = mdl_pick(src_req & mdl_mask, mdl_ptr);
        exp_grant = 4'(1 << exp_idx);
        wait_grant(seen);
        checks++;
        if (!seen || src_grant !== exp_grant) begin
            errors++;
            $display("FAIL grant got=%b expected=%b", src_grant, exp_grant);
            return;
        end
        mdl_ptr = (exp_idx + 1) % 4;
        tick();
        checks++;
        if (sync_enable !== 1'b1 || last_src !== 3'(exp_idx) || delay_count !== mdl_delay) begin
            errors++;
            $display("FAIL fire_entry sync=%b last=%0d delay=%h expected sync=1 last=%0d delay=%h",
                     sync_enable, last_src, delay_count, exp_idx, mdl_delay);
        end
        if (fall_cyc >= 0) begin
            checks++;
            if (cyc - fall_cyc < GAP) begin
                errors++;
                $display("FAIL rearm_gap got=%0d required>=%0d", cyc - fall_cyc, GAP);
            end
        end
        held = 1'b1;
        for (int h = 1; h < trig_after; h++) begin
            tick();
            if (sync_enable !== 1'b1 || src_grant !== 4'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL sync_held got=0 expected=1 for %0d cycles", trig_after);
        end
        trig_done_in = 1'b1;
        tick();
        trig_done_in = 1'b0;
        src_req = next_req;
        checks++;
        if (sync_enable !== 1'b0 || trig_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL release_entry sync=%b cnt=%0d expected sync=0 cnt=%0d",
                     sync_enable, trig_count, exp_cnt);
        end
        fall_cyc = cyc;
        done_cnt = 0; done_at = -1; low_ok = 1'b1;
        for (int n = 1; n <= GAP; n++) begin
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (sync_enable !== 1'b0) low_ok = 1'b0;
        end
        checks++;
        if (!low_ok || (exp_done ? (done_cnt != 1 || done_at != GAP || busy !== 1'b0)
                                 : (done_cnt != 0 || busy !== 1'b1))) begin
            errors++;
            $display("FAIL gap_done pulses=%0d at=%0d busy=%b low=%b expected pulses=%0d at=%0d busy=%b",
                     done_cnt, done_at, busy, low_ok, exp_done, exp_done ? GAP : -1, !exp_done);
        end
        $display("visit src=%0d count=%0d done=%0d", exp_idx, exp_cnt, done_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({src_grant, sync_enable, delay_count, busy, done, timeout_err, trig_count, last_src} !== '0) begin
            errors++;
            $display("FAIL reset_outputs grant=%b sync=%b delay=%h busy=%b done=%b err=%b cnt=%0d last=%0d expected all 0",
                     src_grant, sync_enable, delay_count, busy, done, timeout_err, trig_count, last_src);
        end
        rst_n = 1'b1;
        src_req = 4'b1111;
        tick();
        checks++;
        if (busy !== 1'b0 || src_grant !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_grant busy=%b grant=%b expected 0 0000", busy, src_grant);
        end
        mdl_ptr = 0;
        $display("reset done");
    endtask

    task automatic test_round_robin();
        src_req = 4'b1111;
        arm_seq(4'b1111, 12'($urandom), 16'd0, 16'd4);
        for (int i = 0; i < 4; i++) do_visit($urandom_range(1, 8), 4'b1111, i == 3, i + 1);
        checks++;
        if (last_src !== 3'd3) begin
            errors++;
            $display("FAIL rr_last_src got=%0d expected=3", last_src);
        end
        tick(); tick();
        checks++;
        if (src_grant !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle grant=%b busy=%b expected 0000 0", src_grant, busy);
        end
    endtask

    task automatic test_single_trigger();
        src_req = 4'b0001;
        arm_seq(4'b0001, 12'($urandom), 16'd0, 16'd1);
        do_visit(5, 4'b0001, 1'b1, 1);
        tick(); tick();
        checks++;
        if (trig_count !== 16'd1 || src_grant !== 4'b0) begin
            errors++;
            $display("FAIL single_final cnt=%0d grant=%b expected 1 0000", trig_count, src_grant);
        end
    endtask

    task automatic test_timeout();
        int exp_idx, hi;
        bit seen, done_seen;
        src_req = 4'b0001;
        arm_seq(4'b0001, 12'($urandom), 16'd20, 16'd2);
        exp_idx = mdl_pick(src_req & mdl_mask, mdl_ptr);
        wait_grant(seen);
        checks++;
        if (!seen || src_grant !== 4'(1 << exp_idx)) begin
            errors++;
            $display("FAIL to_grant got=%b expected=%b", src_grant, 4'(1 << exp_idx));
        end
        mdl_ptr = (exp_idx + 1) % 4;
        hi = 0; done_seen = 1'b0;
        tick();
        while (sync_enable === 1'b1 && hi < 100) begin
            hi++;
            if (done === 1'b1) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (hi != 20) begin
            errors++;
            $display("FAIL timeout_len got=%0d expected=20", hi);
        end
        tick(); tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || done_seen || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state err=%b busy=%b done=%b expected 1 0 0", timeout_err, busy, done_seen | done);
        end
        $display("timeout after %0d cycles", hi);
        src_req = 4'b0000;
        arm_seq(4'b0001, 12'($urandom), 16'd20, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_armed busy=%b err=%b expected 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_trig_vs_timeout();
        src_req = 4'b0001;
        arm_seq(4'b0001, 12'($urandom), 16'd6, 16'd1);
        do_visit(6, 4'b0000, 1'b1, 1);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL trig_beats_timeout err=%b expected=0", timeout_err);
        end
    endtask

    task automatic test_abort();
        int exp_idx;
        bit seen, quiet;
        src_req = 4'b0011;
        arm_seq(4'b0011, 12'($urandom), 16'd0, 16'd3);
        do_visit($urandom_range(1, 6), 4'b0011, 1'b0, 1);
        exp_idx = mdl_pick(src_req & mdl_mask, mdl_ptr);
        wait_grant(seen);
        checks++;
        if (!seen || src_grant !== 4'(1 << exp_idx)) begin
            errors++;
            $display("FAIL abort_grant got=%b expected=%b", src_grant, 4'(1 << exp_idx));
        end
        mdl_ptr = (exp_idx + 1) % 4;
        tick(); tick();
        abort = 1'b1;
        trig_done_in = 1'b1;
        tick();
        abort = 1'b0;
        trig_done_in = 1'b0;
        src_req = 4'b0000;
        checks++;
        if (busy !== 1'b0 || sync_enable !== 1'b0 || trig_count !== 16'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_fire busy=%b sync=%b cnt=%0d done=%b expected 0 0 1 0",
                     busy, sync_enable, trig_count, done);
        end
        quiet = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done !== 1'b0 || sync_enable !== 1'b0 || timeout_err !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abort_quiet got=0 expected=1");
        end
    endtask

    task automatic test_unlimited();
        src_req = 4'b1111;
        arm_seq(4'b1111, 12'($urandom), 16'd0, 16'd0);
        for (int i = 0; i < 10; i++) do_visit($urandom_range(1, 8), 4'($urandom_range(1, 15)), 1'b0, i + 1);
        checks++;
        if (trig_count !== 16'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL unlimited cnt=%0d busy=%b expected 10 1", trig_count, busy);
        end
        src_req = 4'b0000;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || trig_count !== 16'd10) begin
            errors++;
            $display("FAIL unlimited_abort busy=%b cnt=%0d expected 0 10", busy, trig_count);
        end
    endtask

    task automatic test_reset_mid_fire();
        bit seen;
        src_req = 4'b0001;
        arm_seq(4'b0001, 12'($urandom_range(1, 4095)), 16'd0, 16'd2);
        wait_grant(seen);
        checks++;
        if (!seen || src_grant !== 4'b0001) begin
            errors++;
            $display("FAIL rst_grant got=%b expected=0001", src_grant);
        end
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({src_grant, sync_enable, delay_count, busy, done, timeout_err, trig_count, last_src} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fire grant=%b sync=%b delay=%h busy=%b done=%b err=%b cnt=%0d last=%0d expected all 0",
                     src_grant, sync_enable, delay_count, busy, done, timeout_err, trig_count, last_src);
        end
        rst_n = 1'b1;
        mdl_ptr = 0;
        src_req = 4'b0011;
        arm_seq(4'b0011, 12'($urandom), 16'd0, 16'd1);
        do_visit(3, 4'b0000, 1'b1, 1);
    endtask

    task automatic test_random();
        logic [3:0] m, nr;
        int nt;
        for (int s = 0; s < 4; s++) begin
            m  = 4'($urandom_range(1, 15));
            nt = $urandom_range(1, 3);
            src_req = 4'($urandom) & m;
            if (src_req == 4'b0) src_req = m;
            arm_seq(m, 12'($urandom), ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(9, 300)), 16'(nt));
            for (int v = 0; v < nt; v++) begin
                nr = 4'($urandom) & m;
                if (nr == 4'b0) nr = m;
                do_visit($urandom_range(1, 8), nr, v == nt - 1, v + 1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0;
        cfg_src_mask = 4'b0; cfg_delay = 12'b0; cfg_timeout = 16'b0; cfg_num_trig = 16'b0;
        src_req = 4'b0; trig_done_in = 1'b0;
        test_reset();
        test_round_robin();
        test_single_trigger();
        test_timeout();
        test_trig_vs_timeout();
        test_abort();
        test_unlimited();
        test_reset_mid_fire();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_arm_ctrl.md
Name: trigger_arm_ctrl

Overview:
Sequencer and arbiter placed in front of the trigger synchroniser. It accepts trigger requests from up to NUM_SRC sources (software, external pin, timer, cascade) and grants one at a time, round-robin. It drives the synchroniser's sync_enable and delay_count, watches its trigger output, and enforces re-arm gaps, a bounded trigger count and a timeout.

Parameters:
NUM_SRC, 4, number of trigger request sources (1..8)
TIMEOUT_W, 16, width of timeout counter
CNT_W, 16, width of trigger-count registers
GAP_CYCLES, 8, minimum sync_enable low time between triggers; must be >= 8 so the synchroniser's stable-wait completes

Ports:
ref_clk  in  1  clock
rst_n  in  1  synchronous active-low reset
arm  in  1  single-cycle pulse, starts a sequence
abort  in  1  single-cycle pulse, cancels the sequence
cfg_src_mask  in  NUM_SRC  enabled sources
cfg_delay  in  12  delay value forwarded to the synchroniser
cfg_timeout  in  TIMEOUT_W  max cycles in FIRE; 0 disables the timeout
cfg_num_trig  in  CNT_W  triggers per sequence; 0 means unlimited
src_req  in  NUM_SRC  level requests, already synchronous to ref_clk
trig_done_in  in  1  synchroniser trigger output, active high after polarity handling
src_grant  out  NUM_SRC  one-hot, one-cycle grant pulse
sync_enable  out  1  to synchroniser
delay_count  out  12  to synchroniser
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when a sequence completes normally
timeout_err  out  1  sticky error flag; cleared by arm or reset
trig_count  out  CNT_W  triggers completed in the current sequence
last_src  out  3  index of the last granted source

Behaviour:
- All state is clocked on posedge ref_clk. rst_n is synchronous and active low.
- Reset values: every output 0; state IDLE; round-robin pointer 0.
- Latched at arm in IDLE: cfg_src_mask, cfg_delay, cfg_timeout, cfg_num_trig. delay_count is registered from the latched cfg_delay and is stable for the whole sequence.
- arm outside IDLE is ignored.
- States are one-hot: IDLE, ARMED, FIRE, RELEASE.
- IDLE:
  - on arm: go to ARMED, clear trig_count and timeout_err.
- ARMED:
  - Qualified requests are req_q = src_req & mask.
  - If req_q != 0: grant the first set bit at or after the round-robin pointer, wrapping around. Pulse src_grant for that cycle, set last_src to that index, set the pointer to index+1 mod NUM_SRC, go to FIRE.
  - Grant-to-sync_enable latency is 1 cycle: sync_enable is registered high on FIRE entry.
  - With no request, stay in ARMED.
- FIRE:
  - sync_enable = 1 and the timeout counter increments each cycle.
  - On a rising edge of trig_done_in (registered edge detect): drop sync_enable next cycle, increment trig_count, go to RELEASE.
  - If cfg_timeout != 0 and the counter reaches cfg_timeout with no edge: drop sync_enable, set timeout_err, go to IDLE with no done pulse.
  - If a trigger edge and the timeout occur in the same cycle, the trigger wins.
- RELEASE:
  - sync_enable = 0 for exactly GAP_CYCLES cycles.
  - Then, if cfg_num_trig != 0 and trig_count == cfg_num_trig: pulse done and go to IDLE.
  - Otherwise return to ARMED.
- trig_count saturates at all-ones; it never wraps.
- abort in any non-IDLE state: go to IDLE the next cycle with sync_enable = 0. trig_count is held; no done pulse, no error.
- abort has priority over arm, trigger and timeout in the same cycle.
- Reset mid-sequence: immediate return to reset values. sync_enable must never glitch high during or after reset.
- A request held high across sequences is granted once per ARMED visit only.
- A mask of all zeros leaves the block parked in ARMED until abort.

Decomposition:
- Package trig_ctrl_pkg holds:
  - the one-hot state typedef (IDLE=1, ARMED=2, FIRE=4, RELEASE=8);
  - the GAP_CYCLES default;
  - the localparam for the last_src width.
- One sub-module, rr_arbiter: NUM_SRC requests plus pointer in, one-hot grant and index out, combinational. It is instantiated in ARMED.

Test Plan:
- Single trigger:
  - Stimulus: cfg_num_trig=1, mask=4'b0001, arm, src_req[0]=1; trig_done_in rises 5 cycles after sync_enable.
  - Required: one src_grant[0] pulse; sync_enable high 1 cycle after the grant; sync_enable low after the edge; done pulses 8 cycles after sync_enable falls; trig_count=1.
- Round-robin:
  - Stimulus: mask=4'b1111, all requests held, cfg_num_trig=4.
  - Required: grants in order 0,1,2,3; last_src ends at 3; done after the 4th RELEASE.
- Timeout:
  - Stimulus: cfg_timeout=20, trig_done_in held low.
  - Required: sync_enable falls after 20 FIRE cycles; timeout_err=1; state IDLE; no done pulse.
  - Then: a fresh arm clears timeout_err.
- Abort:
  - Stimulus: abort in FIRE on the same cycle as a trig_done_in edge.
  - Required: IDLE next cycle, sync_enable=0, trig_count unchanged, no done pulse.
- Unlimited mode:
  - Stimulus: cfg_num_trig=0, 10 triggers.
  - Required: trig_count=10, busy stays 1, no done pulse; every low gap on sync_enable is >= 8 cycles.
- Reset mid-FIRE:
  - Stimulus: rst_n low for 1 cycle.
  - Required: all outputs 0 on the next edge; a following arm works normally.
